// File: rtl/lcd_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lcd_ctrl_sequencer
// Brief   : HD44780-class command sequencer feeding a byte-level LCD driver,
//           with internal execution-delay timing and cursor tracking.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_ctrl_sequencer #(
  parameter int TICKS_PER_US = 50,
  parameter int MODE         = 1,
  parameter int LINES        = 1,
  parameter int COLS         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd_in,
  input  logic       cmd_valid,
  output logic       cmd_rdy,
  input  logic [7:0] data_in,
  output logic       drv_valid,
  input  logic       drv_rdy,
  output logic       drv_rs,
  output logic [7:0] drv_byte,
  output logic       init_done,
  output logic       ctrl_error,
  output logic       cur_line,
  output logic [5:0] cur_col
);

  localparam int c_CNT_W = $clog2(15000 * TICKS_PER_US + 1);
  localparam logic [c_CNT_W-1:0] c_T_PWR   = c_CNT_W'(15000 * TICKS_PER_US);
  localparam logic [c_CNT_W-1:0] c_T_LONG  = c_CNT_W'(1640 * TICKS_PER_US);
  localparam logic [c_CNT_W-1:0] c_T_SHORT = c_CNT_W'(42 * TICKS_PER_US);

  localparam logic [2:0] c_CMD_INIT     = 3'd1;
  localparam logic [2:0] c_CMD_CLEAR    = 3'd2;
  localparam logic [2:0] c_CMD_HOME     = 3'd3;
  localparam logic [2:0] c_CMD_WRITE    = 3'd4;
  localparam logic [2:0] c_CMD_SET_POS  = 3'd5;
  localparam logic [2:0] c_CMD_DISP_OFF = 3'd6;
  localparam logic [2:0] c_CMD_DISP_ON  = 3'd7;

  localparam logic       c_TWO_LINES = (LINES != 0);
  localparam logic [7:0] c_FUNC_SET  = {2'b00, 1'b1, (MODE == 0), c_TWO_LINES, 3'b000};
  localparam logic [7:0] c_B_ENTRY   = 8'h06;
  localparam logic [7:0] c_B_DISP_ON = 8'h0C;
  localparam logic [7:0] c_B_DISP_OF = 8'h08;
  localparam logic [7:0] c_B_CLEAR   = 8'h01;
  localparam logic [7:0] c_B_HOME    = 8'h02;
  localparam logic [5:0] c_COLS      = 6'(COLS);
  localparam logic [5:0] c_LAST_COL  = 6'(COLS - 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT  = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_EXEC_WAIT = 3'd3,
    S_NEXT      = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_op;
  logic [1:0]         r_step;
  logic [6:0]         r_pos;
  logic               r_long;
  logic               r_cmd_rdy;
  logic               r_drv_valid;
  logic               r_drv_rs;
  logic [7:0]         r_drv_byte;
  logic               r_init_done;
  logic               r_ctrl_error;
  logic               r_cur_line;
  logic [5:0]         r_cur_col;

  logic       w_accept;
  logic       w_issue;
  logic       w_reject;
  logic [7:0] w_byte;
  logic       w_rs;
  logic       w_long;
  logic       w_pos_bad;
  logic       w_wrap_line;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid && r_cmd_rdy;
  assign w_pos_bad   = (data_in[5:0] >= c_COLS) || (data_in[6] && !c_TWO_LINES);
  assign w_wrap_line = c_TWO_LINES & ~r_cur_line;

  // Selects the byte to launch next, either from a fresh command or from the
  // running multi-byte sequence.
  always_comb begin
    w_issue  = 1'b0;
    w_reject = 1'b0;
    w_byte   = 8'h00;
    w_rs     = 1'b0;
    w_long   = 1'b0;
    if (w_accept) begin
      case (cmd_in)
        c_CMD_INIT:     begin w_issue = 1'b1; w_byte = c_FUNC_SET; end
        c_CMD_CLEAR:    begin w_issue = r_init_done; w_byte = c_B_CLEAR; w_long = 1'b1; end
        c_CMD_HOME:     begin w_issue = r_init_done; w_byte = c_B_HOME;  w_long = 1'b1; end
        c_CMD_DISP_OFF: begin w_issue = r_init_done; w_byte = c_B_DISP_OF; end
        c_CMD_DISP_ON:  begin w_issue = r_init_done; w_byte = c_B_DISP_ON; end
        c_CMD_WRITE:    begin w_issue = r_init_done; w_byte = data_in; w_rs = 1'b1; end
        c_CMD_SET_POS:  begin
          w_issue = r_init_done && !w_pos_bad;
          w_byte  = {1'b1, data_in[6:0]};
        end
        default: ;
      endcase
      w_reject = (cmd_in != 3'd0) && (cmd_in != c_CMD_INIT) && !w_issue;
    end else if (r_state == S_NEXT) begin
      case (r_op)
        c_CMD_INIT: begin
          case (r_step)
            2'd0:    begin w_issue = 1'b1; w_byte = c_B_ENTRY; end
            2'd1:    begin w_issue = 1'b1; w_byte = c_B_DISP_ON; end
            2'd2:    begin w_issue = 1'b1; w_byte = c_B_CLEAR; w_long = 1'b1; end
            default: ;
          endcase
        end
        c_CMD_WRITE: begin
          w_issue = (r_step == 2'd0) && (r_cur_col == c_LAST_COL);
          w_byte  = {1'b1, w_wrap_line, 6'b000000};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_PWR_WAIT;
      r_cnt        <= c_T_PWR - 1'b1;
      r_op         <= 3'd0;
      r_step       <= 2'd0;
      r_pos        <= 7'd0;
      r_long       <= 1'b0;
      r_cmd_rdy    <= 1'b0;
      r_drv_valid  <= 1'b0;
      r_drv_rs     <= 1'b0;
      r_drv_byte   <= 8'h00;
      r_init_done  <= 1'b0;
      r_ctrl_error <= 1'b0;
      r_cur_line   <= 1'b0;
      r_cur_col    <= 6'd0;
    end else begin
      r_ctrl_error <= 1'b0;
      case (r_state)
        S_PWR_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= S_IDLE;
            r_cmd_rdy <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= cmd_in;
            r_step <= 2'd0;
            r_pos  <= data_in[6:0];
            if (cmd_in == c_CMD_INIT) r_init_done <= 1'b0;
            if (w_reject) begin
              r_state      <= S_ERR;
              r_ctrl_error <= 1'b1;
              r_cmd_rdy    <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (drv_rdy) begin
            r_drv_valid <= 1'b0;
            r_cnt       <= (r_long ? c_T_LONG : c_T_SHORT) - 1'b1;
            r_state     <= S_EXEC_WAIT;
          end
        end
        S_EXEC_WAIT: begin
          if (r_cnt == '0) r_state <= S_NEXT;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_NEXT: begin
          r_step <= r_step + 2'd1;
          if (!w_issue) begin
            r_state   <= S_IDLE;
            r_cmd_rdy <= 1'b1;
          end
          case (r_op)
            c_CMD_INIT: begin
              if (r_step == 2'd3) begin
                r_init_done <= 1'b1;
                r_cur_line  <= 1'b0;
                r_cur_col   <= 6'd0;
              end
            end
            c_CMD_CLEAR, c_CMD_HOME: begin
              r_cur_line <= 1'b0;
              r_cur_col  <= 6'd0;
            end
            c_CMD_WRITE: begin
              if (r_step == 2'd0) begin
                if (r_cur_col == c_LAST_COL) begin
                  r_cur_col  <= 6'd0;
                  r_cur_line <= w_wrap_line;
                end else begin
                  r_cur_col <= r_cur_col + 6'd1;
                end
              end
            end
            c_CMD_SET_POS: begin
              r_cur_line <= r_pos[6];
              r_cur_col  <= r_pos[5:0];
            end
            default: ;
          endcase
        end
        S_ERR: begin
          r_state   <= S_IDLE;
          r_cmd_rdy <= 1'b1;
        end
        default: begin
          r_state <= S_PWR_WAIT;
          r_cnt   <= c_T_PWR - 1'b1;
        end
      endcase
      // A launched byte overrides the idle/return decision made above.
      if (w_issue) begin
        r_state     <= S_ISSUE;
        r_drv_valid <= 1'b1;
        r_drv_byte  <= w_byte;
        r_drv_rs    <= w_rs;
        r_long      <= w_long;
        r_cmd_rdy   <= 1'b0;
      end
    end
  end

  assign cmd_rdy    = r_cmd_rdy;
  assign drv_valid  = r_drv_valid;
  assign drv_rs     = r_drv_rs;
  assign drv_byte   = r_drv_byte;
  assign init_done  = r_init_done;
  assign ctrl_error = r_ctrl_error;
  assign cur_line   = r_cur_line;
  assign cur_col    = r_cur_col;

endmodule
`default_nettype wire

// File: doc/lcd_ctrl_sequencer.md
Name: lcd_ctrl_sequencer

Overview:
Parametrised command sequencer for HD44780-class character LCDs (1602/2004). It sits between the user command interface and the existing byte-level LCD driver.
- Expands high-level commands (INIT, CLEAR, HOME, WRITE, SET_POS, DISP_ON/OFF) into driver byte transfers.
- Times every transfer with an internal execution-delay counter; it does not use external timer flags.
- Tracks the cursor position and wraps lines automatically.

Parameters:
TICKS_PER_US, 50, clk cycles per microsecond; all delays are computed from it (1 in simulation).
MODE, 1, bus mode: 0 = 8-bit, 1 = 4-bit; sets the DL bit of FUNCTION_SET.
LINES, 1, 0 = 1 line, 1 = 2 lines; sets the N bit and the wrap target.
COLS, 16, visible columns per line (1..40).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_in  in  3  0 NOP, 1 INIT, 2 CLEAR, 3 HOME, 4 WRITE, 5 SET_POS, 6 DISP_OFF, 7 DISP_ON
cmd_valid  in  1  command request
cmd_rdy  out  1  sequencer idle; a command is accepted when cmd_valid & cmd_rdy
data_in  in  8  WRITE: character code; SET_POS: [6] = line, [5:0] = column
drv_valid  out  1  byte request to the driver
drv_rdy  in  1  driver has completed the byte transfer
drv_rs  out  1  0 = instruction, 1 = data
drv_byte  out  8  byte to the driver
init_done  out  1  INIT sequence completed
ctrl_error  out  1  one-cycle pulse marking a rejected command
cur_line  out  1  current cursor line
cur_col  out  6  current cursor column

Behaviour:
- Reset values: cmd_rdy 0, drv_valid 0, drv_rs 0, drv_byte 0x00, init_done 0, ctrl_error 0, cur_line 0, cur_col 0. State goes to PWR_WAIT.
- rst at any cycle, including mid-transfer or mid-delay, aborts the operation and reapplies the reset values next edge. The power-up wait then restarts.
- Delay counter width is clog2(15000*TICKS_PER_US+1). Delays:
  - T_PWR = 15000 us
  - T_LONG = 1640 us, for CLEAR and HOME
  - T_SHORT = 42 us, for all other bytes
- States:
  - PWR_WAIT: count T_PWR, then go to IDLE.
  - IDLE: cmd_rdy = 1.
  - ISSUE: drv_valid = 1.
  - EXEC_WAIT: count the execution delay.
  - NEXT: choose the next byte of the sequence, or return to IDLE.
- Accept: cmd_valid & cmd_rdy in IDLE.
  - cmd_rdy falls on the next edge.
  - drv_valid rises on the same edge, with drv_byte and drv_rs valid and stable.
- drv_valid holds until drv_rdy is sampled high. On the next edge drv_valid = 0, the delay is loaded and EXEC_WAIT is entered.
- drv_rdy seen outside ISSUE is ignored.
- NOP is accepted and ignored: no transfer, and cmd_rdy stays 1.
- INIT sequence, all bytes rs = 0:
  - FUNCTION_SET = 0x20 | (~MODE<<4) | (LINES<<3)
  - ENTRY = 0x06
  - DISP_ON = 0x0C
  - CLEAR = 0x01 (T_LONG)
  - After the last delay: init_done = 1, cur_line = 0, cur_col = 0, then IDLE.
  - INIT is legal at any time and clears init_done at acceptance.
- Single-byte commands, all rs = 0:
  - CLEAR 0x01 (T_LONG): cursor reset to 0,0.
  - HOME 0x02 (T_LONG): cursor reset to 0,0.
  - DISP_OFF 0x08.
  - DISP_ON 0x0C.
- WRITE: send data_in with rs = 1, then cur_col += 1.
  - If cur_col reaches COLS, an address byte (rs = 0) is sent before returning to IDLE, and cur_col = 0.
  - LINES = 1: cur_line toggles and the byte is 0x80 | (new_line ? 0x40 : 0x00).
  - LINES = 0: line stays 0 and the byte is 0x80.
- SET_POS:
  - Column data_in[5:0] >= COLS, or data_in[6] = 1 while LINES = 0, is rejected.
  - Otherwise send 0x80 | (line<<6) | col and update the cursor.
- Rejection: for any command other than NOP/INIT while init_done = 0, or an invalid SET_POS:
  - ctrl_error pulses for 1 cycle after acceptance.
  - No drv_valid; cmd_rdy is 1 again on the next edge.
- cmd_valid while cmd_rdy = 0 is ignored; no error is raised.
- data_in is captured at acceptance; later changes have no effect.

Test Plan:
All tests use TICKS_PER_US = 1, MODE = 1, LINES = 1, COLS = 16.
1. Release rst -> cmd_rdy stays 0 for 15000 cycles, then goes to 1; init_done = 0 and drv_valid never rises.
2. INIT -> bytes 0x28, 0x06, 0x0C, 0x01, all rs = 0. After each drv_rdy the gap to the next drv_valid is at least 42/42/42/1640 cycles. Then init_done = 1 and cmd_rdy = 1. Vary drv_rdy latency from 0 to 5 cycles; drv_byte must stay stable while drv_valid is high.
3. Before INIT, WRITE 0x41 -> ctrl_error pulses exactly 1 cycle, there is no driver transfer, and cmd_rdy returns to 1.
4. After INIT, 16 WRITEs of 0x30..0x3F -> 16 rs = 1 bytes, then 0xC0 with rs = 0 inside the 16th command. cur_line = 1, cur_col = 0. A 17th WRITE gives cur_col = 1. Another 16 WRITEs wrap to 0x80 with cur_line = 0.
5. SET_POS 0x52 -> ctrl_error pulses and there is no transfer. SET_POS 0x45 -> byte 0xC5 with rs = 0, cur_line = 1, cur_col = 5.
6. Assert rst 100 cycles into the CLEAR delay -> all outputs take reset values next edge, init_done = 0, and the power-up wait restarts at 15000 cycles. A cmd_valid pulse during busy is ignored, with no error.
